// File: rtl/skewed_data_delivery.sv
// Lockstep unload of 2*LANES word FIFOs, serialised LSB-first onto west/north byte lanes.
// Optional build macro DDE_SKEW_EN delays lane k by k cycles (systolic skew) and adds a DRAIN phase.
module skewed_data_delivery #(
    parameter int W     = 32,
    parameter int LANES = 4,
    parameter int DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   flush,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [W-1:0]                           in_data,
    input  logic                                   in_side,
    input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] in_lane,
    output logic                                   rptr_en,
    output logic [LANES*8-1:0]                     west_data,
    output logic [LANES*8-1:0]                     north_data,
    output logic [LANES-1:0]                       west_valid,
    output logic [LANES-1:0]                       north_valid,
    output logic                                   busy
);
    localparam int BYTES = W / 8;
    localparam int NF    = 2 * LANES;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE  = BCW'(BYTES - 1);
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t         state_reg;
    logic [BCW-1:0] byte_cnt_reg;
    logic           rptr_en_reg;
`ifdef DDE_SKEW_EN
    localparam int DCW = (LANES > 2) ? $clog2(LANES - 1) : 1;
    localparam logic [DCW-1:0] LAST_DRAIN = DCW'((LANES > 1) ? LANES - 2 : 0);
    logic [DCW-1:0] drain_cnt_reg;
`endif

    wire [NF-1:0]   wr_sel;
    wire [NF-1:0]   full;
    wire [NF-1:0]   nonempty;
    wire [NF-1:0]   lane_valids;
    wire [8*NF-1:0] lane_bytes;
    logic lane_ok, accept, all_nonempty, last_byte, pop, shift;

    assign lane_ok      = int'(in_lane) < LANES;
    assign in_ready     = !reset && !flush && lane_ok && ((wr_sel & full) == '0);
    assign accept       = in_valid && in_ready;
    assign all_nonempty = &nonempty;
    assign last_byte    = (state_reg == STREAM) && (byte_cnt_reg == LAST_BYTE);
    // Unified read: every FIFO pops together, from IDLE or on the last byte of a stream.
    assign pop          = !reset && !flush && all_nonempty && ((state_reg == IDLE) || last_byte);
    assign shift        = (state_reg == STREAM) && !pop;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
            rptr_en_reg  <= 1'b0;
`ifdef DDE_SKEW_EN
            drain_cnt_reg <= '0;
`endif
        end else begin
            rptr_en_reg <= accept;
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        state_reg    <= STREAM;
                        byte_cnt_reg <= '0;
                    end
                end
                STREAM: begin
                    if (last_byte) begin
                        byte_cnt_reg <= '0;
                        if (!pop) begin
`ifdef DDE_SKEW_EN
                            if (LANES > 1) state_reg <= DRAIN;
                            else           state_reg <= IDLE;
`else
                            state_reg <= IDLE;
`endif
                        end
                    end else begin
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
                    end
                end
`ifdef DDE_SKEW_EN
                DRAIN: begin
                    if (drain_cnt_reg == LAST_DRAIN) begin
                        state_reg     <= IDLE;
                        drain_cnt_reg <= '0;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 1'b1;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NF; gi++) begin : g_fifo
        localparam int LANE = gi % LANES;
        localparam bit SIDE = (gi >= LANES);

        logic [W-1:0]  mem [DEPTH];
        logic [PW-1:0] wr_ptr_reg;
        logic [PW-1:0] rd_ptr_reg;
        logic [CW-1:0] count_reg;
        logic [W-1:0]  word_reg;
        logic          wr_en;
        logic          base_valid;
        logic [7:0]    base_byte;

        assign wr_sel[gi]   = (in_side == SIDE) && (in_lane == LW'(LANE));
        assign full[gi]     = (count_reg == FULL_COUNT);
        assign nonempty[gi] = (count_reg != '0);
        assign wr_en        = accept && wr_sel[gi];

        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_ptr_reg] <= in_data;
        end

        // word_reg doubles as the registered RAM read and the byte serialiser.
        always_ff @(posedge clk) begin
            if (reset || flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
                word_reg   <= '0;
            end else begin
                if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    word_reg   <= mem[rd_ptr_reg];
                end else if (shift) begin
                    word_reg <= word_reg >> 8;
                end
                if (wr_en && !pop)      count_reg <= count_reg + 1'b1;
                else if (pop && !wr_en) count_reg <= count_reg - 1'b1;
            end
        end

        assign base_valid = (state_reg == STREAM);
        assign base_byte  = base_valid ? word_reg[7:0] : 8'h00;

`ifdef DDE_SKEW_EN
        if (LANE > 0) begin : g_skew
            logic [7:0]      pipe_byte_reg [LANE];
            logic [LANE-1:0] pipe_valid_reg;

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    for (int j = 0; j < LANE; j++) pipe_byte_reg[j] <= 8'h00;
                    pipe_valid_reg <= '0;
                end else begin
                    pipe_byte_reg[0]  <= base_byte;
                    pipe_valid_reg[0] <= base_valid;
                    for (int j = 1; j < LANE; j++) begin
                        pipe_byte_reg[j]  <= pipe_byte_reg[j-1];
                        pipe_valid_reg[j] <= pipe_valid_reg[j-1];
                    end
                end
            end

            assign lane_bytes[8*gi +: 8] = pipe_byte_reg[LANE-1];
            assign lane_valids[gi]       = pipe_valid_reg[LANE-1];
        end else begin : g_direct
            assign lane_bytes[8*gi +: 8] = base_byte;
            assign lane_valids[gi]       = base_valid;
        end
`else
        assign lane_bytes[8*gi +: 8] = base_byte;
        assign lane_valids[gi]       = base_valid;
`endif
    end

    assign rptr_en     = rptr_en_reg;
    assign busy        = (state_reg != IDLE);
    assign west_data   = lane_bytes[8*LANES-1:0];
    assign north_data  = lane_bytes[8*NF-1:8*LANES];
    assign west_valid  = lane_valids[LANES-1:0];
    assign north_valid = lane_valids[NF-1:LANES];

endmodule

// File: tb/tb_skewed_data_delivery.sv
// Randomised self-checking bench for skewed_data_delivery against a queue/schedule reference model.
// Honours DDE_SKEW_EN in the same way as the design.
module tb_skewed_data_delivery;
    localparam int W     = 32;
    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int BYTES = W / 8;
    localparam int NF    = 2 * LANES;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
`ifdef DDE_SKEW_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif
    localparam int D    = SKEW * (LANES - 1);
    localparam int RING = 64;
    localparam int OW   = 16 * LANES + 2 * LANES + 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_side = 1'b0;
    logic [LW-1:0]   in_lane = '0;
    logic [W-1:0]    in_data = '0;
    wire             in_ready, rptr_en, busy;
    wire [8*LANES-1:0] west_data, north_data;
    wire [LANES-1:0] west_valid, north_valid;

    always #5 clk = ~clk;

    skewed_data_delivery #(.W(W), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_side(in_side), .in_lane(in_lane), .rptr_en(rptr_en),
        .west_data(west_data), .north_data(north_data),
        .west_valid(west_valid), .north_valid(north_valid), .busy(busy)
    );

    wire [OW-1:0] obs = {west_data, north_data, west_valid, north_valid, busy, in_ready, rptr_en};

    // Reference model: per-FIFO word queues plus a per-cycle schedule of expected lane bytes.
    logic [W-1:0] q [NF][$];
    logic [8:0]   sched [RING][NF];
    int           cyc = 0;
    int           last_pop = -1000;
    bit           prev_acc = 1'b0;
    logic [OW-1:0] exp_vec;
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic model_step();
        logic [8*LANES-1:0] ewd, ndd;
        logic [LANES-1:0]   ewv, nv;
        logic [W-1:0]       w;
        bit erdy, ebusy, acc, pop;
        int sel, slot;
        ewd = '0; ndd = '0; ewv = '0; nv = '0;
        slot = cyc % RING;
        for (int f = 0; f < NF; f++) begin
            if (f < LANES) begin
                ewv[f] = sched[slot][f][8];
                ewd[8*f +: 8] = sched[slot][f][7:0];
            end else begin
                nv[f-LANES] = sched[slot][f][8];
                ndd[8*(f-LANES) +: 8] = sched[slot][f][7:0];
            end
            sched[slot][f] = '0;
        end
        sel   = (in_side ? LANES : 0) + int'(in_lane);
        erdy  = !reset && !flush && (int'(in_lane) < LANES) && (q[sel].size() < DEPTH);
        ebusy = (cyc > last_pop) && (cyc <= last_pop + BYTES + D);
        exp_vec = {ewd, ndd, ewv, nv, ebusy, erdy, prev_acc};
        acc = in_valid && erdy;
        if (reset || flush) begin
            for (int f = 0; f < NF; f++) q[f].delete();
            for (int r = 0; r < RING; r++)
                for (int f = 0; f < NF; f++) sched[r][f] = '0;
            last_pop = -1000;
            prev_acc = 1'b0;
        end else begin
            pop = 1'b1;
            for (int f = 0; f < NF; f++) if (q[f].size() == 0) pop = 1'b0;
            if (!((cyc == last_pop + BYTES) || (cyc > last_pop + BYTES + D))) pop = 1'b0;
            if (pop) begin
                for (int f = 0; f < NF; f++) begin
                    w = q[f].pop_front();
                    for (int b = 0; b < BYTES; b++)
                        sched[(cyc + 1 + b + SKEW * (f % LANES)) % RING][f] = {1'b1, w[8*b +: 8]};
                end
                last_pop = cyc;
            end
            if (acc) q[sel].push_back(in_data);
            prev_acc = acc;
        end
        cyc++;
    endtask

    task automatic drive(bit v, bit side, int lane, logic [W-1:0] data, bit fl);
        in_valid = v;
        in_side  = side;
        in_lane  = LW'(lane);
        in_data  = data;
        flush    = fl;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, '0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) reset = 1'b0;
            @(negedge clk);
            model_step();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
            end
            if (i == 1) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ready_after_reset got=%b exp=1", in_ready);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_all_lanes();
        int t0 = -1, t3 = -1, tb = -1, nv3 = 0;
        logic [W-1:0] seen0 = '0;
        for (int i = 0; i < 40; i++) begin
            if (i < NF) drive(1, i >= LANES, i % LANES, 32'h44332211, 0);
            else        drive(0, 0, 0, '0, 0);
            @(negedge clk);
            model_step();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL all_lanes cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
            end
            if (west_valid[0] === 1'b1) begin
                if (t0 < 0) t0 = i;
                if (i - t0 < BYTES) seen0[8*(i-t0) +: 8] = west_data[7:0];
            end
            if (north_valid[LANES-1] === 1'b1) begin
                nv3++;
                if (t3 < 0) t3 = i;
            end
            if (t0 >= 0 && tb < 0 && busy === 1'b0) tb = i;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen0 !== 32'h44332211) begin
            n_fail++;
            $display("FAIL lane0_bytes got=%h exp=44332211", seen0);
        end
        n_checks++;
        if (t0 < 0 || t3 - t0 != SKEW * (LANES - 1)) begin
            n_fail++;
            $display("FAIL lane3_skew got=%0d exp=%0d", t3 - t0, SKEW * (LANES - 1));
        end
        n_checks++;
        if (nv3 != BYTES) begin
            n_fail++;
            $display("FAIL lane3_count got=%0d exp=%0d", nv3, BYTES);
        end
        n_checks++;
        if (tb - t0 != BYTES + D) begin
            n_fail++;
            $display("FAIL busy_fall got=%0d exp=%0d", tb - t0, BYTES + D);
        end
    endtask

    task automatic test_full();
        int pulses = 0;
        bit rdy5 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 0)     drive(0, 0, 0, '0, 1);
            else if (i < 6) drive(1, 0, 2, W'($urandom), 0);
            else            drive(0, 0, 0, '0, 0);
            @(negedge clk);
            if (i == 5) rdy5 = in_ready;
            if (i > 0 && rptr_en === 1'b1) pulses++;
            model_step();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL fifo_full cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (rdy5 !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_when_full got=%b exp=0", rdy5);
        end
        n_checks++;
        if (pulses != DEPTH) begin
            n_fail++;
            $display("FAIL rptr_pulses got=%0d exp=%0d", pulses, DEPTH);
        end
    endtask

    task automatic test_back_to_back();
        int run = 0, best = 0;
        for (int i = 0; i < 3 * NF + 32; i++) begin
            if (i == 0)                drive(0, 0, 0, '0, 1);
            else if (i <= 3 * NF)      drive(1, ((i - 1) / 3) >= LANES, ((i - 1) / 3) % LANES, W'($urandom), 0);
            else                       drive(0, 0, 0, '0, 0);
            @(negedge clk);
            model_step();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
            end
            if (west_valid[0] === 1'b1) run++;
            else run = 0;
            if (run > best) best = run;
            @(posedge clk); #1;
        end
        n_checks++;
        if (best != 3 * BYTES) begin
            n_fail++;
            $display("FAIL contiguous_run got=%0d exp=%0d", best, 3 * BYTES);
        end
    endtask

    task automatic test_flush_mid();
        int seen = 0, flush_i = -1;
        for (int i = 0; i < 30; i++) begin
            if (i == 0)                           drive(0, 0, 0, '0, 1);
            else if (i <= NF)                     drive(1, (i - 1) >= LANES, (i - 1) % LANES, W'($urandom), 0);
            else if (seen == 1 && flush_i < 0) begin
                drive(0, 0, 0, '0, 1);
                flush_i = i;
            end else                              drive(0, 0, 0, '0, 0);
            @(negedge clk);
            model_step();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL flush_mid cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
            end
            if (flush_i >= 0 && i == flush_i + 1) begin
                n_checks++;
                if ({west_valid, north_valid, busy, in_ready} !== {{(2*LANES){1'b0}}, 1'b0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL after_flush got=%b exp=%b", {west_valid, north_valid, busy, in_ready},
                             {{(2*LANES){1'b0}}, 1'b0, 1'b1});
                end
            end
            if (busy === 1'b1) seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (flush_i < 0) begin
            n_fail++;
            $display("FAIL flush_reached got=%0d exp=stream_started", flush_i);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, LANES - 1),
                  W'($urandom), $urandom_range(0, 79) == 0);
            reset = (i == 300);
            @(negedge clk);
            model_step();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < RING; r++)
            for (int f = 0; f < NF; f++) sched[r][f] = '0;
        test_reset();
        test_all_lanes();
        test_full();
        test_back_to_back();
        test_flush_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t exp=finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
